// File: rtl/nic_pkg.sv
// Shared definitions for the parametrised NIC: PE address map, status word
// layout and the default virtual-channel tag position.
package nic_pkg;

    // PE-visible register map
    typedef enum logic [1:0] {
        INPUT_BUFFER  = 2'b00,
        INPUT_STATUS  = 2'b01,
        OUTPUT_BUFFER = 2'b10,
        OUTPUT_STATUS = 2'b11
    } nic_addr_e;

    // Packet bit that carries the even/odd virtual-channel tag
    localparam int DEFAULT_VC_BIT = 0;

    // Status word layout. Buses are [0:W-1] with bit 0 as the MSB, so the
    // flag and count positions are given as offsets from the LSB end
    // (index W-1), while the overflow flag sits at the MSB (index 0).
    localparam int STAT_FLAG_FROM_LSB = 0;
    localparam int STAT_CNT_FROM_LSB  = 1;
    localparam int STAT_OVF_POS       = 0;

    // Width of an occupancy count wide enough for the deeper of the two FIFOs
    function automatic int cnt_width(input int depth_a, input int depth_b);
        return $clog2((depth_a > depth_b) ? depth_a : depth_b) + 1;
    endfunction

endpackage

// File: rtl/nic_sync_fifo.sv
// Single-clock FIFO used for both NIC directions. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter;
// push is refused when full and pop is refused when empty, both judged on
// registered state, so a push into an empty FIFO is never bypassed out.
module nic_sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [0:W-1]             din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [0:W-1]             head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [0:W-1] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers; reset empties the FIFO and discards everything queued
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/nic_fifo_param.sv
// Parametrised NIC between one PE and one ring router port. Router packets
// land in the input FIFO for the PE to read; PE writes go to the output FIFO
// and leave only in cycles whose ring polarity matches the head packet's
// virtual-channel bit. Strict FIFO order on both sides (head-of-line blocking
// is intended).
module nic_fifo_param
    import nic_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int VC_BIT    = DEFAULT_VC_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di
);

    localparam int CNT_W       = cnt_width(IN_DEPTH, OUT_DEPTH);
    localparam int IN_AW       = $clog2(IN_DEPTH);
    localparam int OUT_AW      = $clog2(OUT_DEPTH);
    localparam int FLAG_IDX    = DATA_W - 1 - STAT_FLAG_FROM_LSB;
    localparam int CNT_LSB_IDX = DATA_W - 1 - STAT_CNT_FROM_LSB;
    localparam int CNT_MSB_IDX = CNT_LSB_IDX - (CNT_W - 1);

    nic_addr_e         addr_e;
    logic              pe_rd;
    logic              pe_wr;

    logic              in_push;
    logic              in_pop;
    logic              in_full;
    logic              in_empty;
    logic [IN_AW:0]    in_count;
    logic [0:DATA_W-1] in_head;

    logic              out_push;
    logic              out_pop;
    logic              out_full;
    logic              out_empty;
    logic [OUT_AW:0]   out_count;
    logic [0:DATA_W-1] out_head;

    logic              overflow;
    logic              ovf_set;
    logic              ovf_clr;
    logic [CNT_W-1:0]  in_count_w;
    logic [CNT_W-1:0]  out_count_w;
    logic [0:DATA_W-1] in_status;
    logic [0:DATA_W-1] out_status;

    assign addr_e = nic_addr_e'(addr);
    assign pe_rd  = nicEn & ~nicWrEn;
    assign pe_wr  = nicEn & nicWrEn;

    assign net_ri  = ~in_full;
    assign in_push = net_si & net_ri;
    assign in_pop  = pe_rd & (addr_e == INPUT_BUFFER);

    assign out_push = pe_wr & (addr_e == OUTPUT_BUFFER);
    assign net_so   = ~out_empty & net_ro & (out_head[VC_BIT] == net_polarity);
    assign out_pop  = net_so;
    assign net_do   = net_so ? out_head : '0;

    assign ovf_set = out_push & out_full;
    assign ovf_clr = pe_rd & (addr_e == OUTPUT_STATUS);

    assign in_count_w  = CNT_W'(in_count);
    assign out_count_w = CNT_W'(out_count);

    nic_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .din   (net_di),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count),
        .head  (in_head)
    );

    nic_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (out_pop),
        .din   (d_in),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count),
        .head  (out_head)
    );

    // Format the two status words from the current registered FIFO state
    always_comb begin
        in_status  = '0;
        out_status = '0;
        in_status[FLAG_IDX]                  = ~in_empty;
        in_status[CNT_MSB_IDX:CNT_LSB_IDX]   = in_count_w;
        out_status[FLAG_IDX]                 = out_full;
        out_status[CNT_MSB_IDX:CNT_LSB_IDX]  = out_count_w;
        out_status[STAT_OVF_POS]             = overflow;
    end

    // Sticky overflow flag: a dropped write sets it, an output-status read clears it, set wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Registered PE read data; anything other than a valid read leaves it unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            d_out <= '0;
        end else if (pe_rd) begin
            case (addr_e)
                INPUT_BUFFER:  d_out <= in_empty ? '0 : in_head;
                INPUT_STATUS:  d_out <= in_status;
                OUTPUT_STATUS: d_out <= out_status;
                default:       d_out <= d_out;
            endcase
        end
    end

endmodule
